// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler that funnels NUM_REQ write streams into one external
// non-showahead FIFO and drains it through a 2-entry skid buffer.
module fifo_rr_scheduler #(
    parameter int NUM_REQ          = 4,
    parameter int FIFO_DATA_WIDTH  = 512,
    parameter int FIFO_DEPTH_RADIX = 3,
    localparam int ID_W            = $clog2(NUM_REQ)
) (
    input  logic                               clock,
    input  logic                               sclr,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*FIFO_DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [FIFO_DATA_WIDTH+ID_W-1:0]    fifo_data,
    output logic                               fifo_wrreq,
    output logic                               fifo_rdreq,
    input  logic [FIFO_DATA_WIDTH+ID_W-1:0]    fifo_q,
    input  logic                               fifo_empty,
    output logic                               fifo_sclr,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FIFO_DATA_WIDTH-1:0]         out_data,
    output logic [ID_W-1:0]                    out_id,
    output logic [FIFO_DEPTH_RADIX:0]          occupancy
);

    localparam int EW = FIFO_DATA_WIDTH + ID_W;
    localparam logic [FIFO_DEPTH_RADIX:0] DEPTH = {1'b1, {FIFO_DEPTH_RADIX{1'b0}}};
    localparam logic [ID_W:0] NUM_REQ_X = (ID_W + 1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]            rr_ptr;
    logic [FIFO_DEPTH_RADIX:0]  occ;
    logic [1:0]                 buf_cnt;
    logic                       buf_head;
    logic                       rd_inflight;
    logic [EW-1:0]              buf_mem [2];

    logic                       space;
    logic                       grant_any;
    logic [ID_W-1:0]            grant_id;
    logic [ID_W:0]              idx;
    logic [NUM_REQ-1:0]         grant;
    logic [FIFO_DATA_WIDTH-1:0] grant_data;
    logic                       pop;
    logic [2:0]                 slots;

    // Search starts at rr_ptr and wraps; the index is kept one bit wider so a
    // non-power-of-two NUM_REQ wraps correctly.
    always_comb begin
        space     = !sclr && (occ < DEPTH);
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (space && !grant_any && req_valid[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        grant      = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (grant_id == ID_W'(i));
            if (grant[i]) begin
                grant_data = req_data[i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
            end
        end
    end

    assign req_ready  = grant;
    assign fifo_wrreq = grant_any;
    assign fifo_data  = {grant_id, grant_data};
    assign fifo_sclr  = sclr;
    assign occupancy  = occ;

    assign out_valid = !sclr && (buf_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = buf_mem[buf_head][FIFO_DATA_WIDTH-1:0];
    assign out_id    = buf_mem[buf_head][EW-1 -: ID_W];

    // A read is issued only if the buffer is guaranteed a free slot when its
    // data lands next cycle, counting the read already in flight.
    assign slots      = {1'b0, buf_cnt} + {2'b00, rd_inflight} - {2'b00, pop};
    assign fifo_rdreq = !sclr && !fifo_empty && (occ != '0) && (slots < 3'd2);

    always_ff @(posedge clock) begin
        if (sclr) begin
            rr_ptr      <= '0;
            occ         <= '0;
            buf_cnt     <= '0;
            buf_head    <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            end
            case ({fifo_wrreq, fifo_rdreq})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            rd_inflight <= fifo_rdreq;
            if (pop) begin
                buf_head <= ~buf_head;
            end
            case ({rd_inflight, pop})
                2'b10:   buf_cnt <= buf_cnt + 1'b1;
                2'b01:   buf_cnt <= buf_cnt - 1'b1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Tail slot is head+count mod 2; with a full buffer and a pop this lands
    // on the slot being vacated, which keeps order intact.
    always_ff @(posedge clock) begin
        if (rd_inflight) begin
            buf_mem[buf_head ^ buf_cnt[0]] <= fifo_q;
        end
    end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the FIFO (2..8).
REQ-002 Parameter FIFO_DATA_WIDTH, default 512: payload width per requester.
REQ-003 Parameter FIFO_DEPTH_RADIX, default 3: FIFO depth is 2**FIFO_DEPTH_RADIX entries; ID_W = clog2(NUM_REQ).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clock  in  1  clock for all logic.
REQ-006 sclr  in  1  synchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester write request.
REQ-008 req_data  in  NUM_REQ*FIFO_DATA_WIDTH  packed payloads; requester i uses slice i.
REQ-009 req_ready  out  NUM_REQ  one-hot grant; requester i's beat accepted when req_valid[i] and req_ready[i] are both high.
REQ-010 fifo_data  out  FIFO_DATA_WIDTH+ID_W  {id, payload} to FIFO write port.
REQ-011 fifo_wrreq  out  1  FIFO write strobe.
REQ-012 fifo_rdreq  out  1  FIFO read strobe; FIFO is non-showahead, so q is valid one cycle after rdreq.
REQ-013 fifo_q  in  FIFO_DATA_WIDTH+ID_W  FIFO read data.
REQ-014 fifo_empty  in  1  FIFO empty flag.
REQ-015 fifo_sclr  out  1  FIFO synchronous clear, equal to sclr.
REQ-016 out_valid, out_ready  out/in  1 each  output stream handshake.
REQ-017 out_data  out  FIFO_DATA_WIDTH  dequeued payload.
REQ-018 out_id  out  ID_W  originating requester index.
REQ-019 occupancy  out  FIFO_DEPTH_RADIX+1  internal FIFO entry count, 0..2**FIFO_DEPTH_RADIX.

Function
REQ-020 Occupancy SHALL be tracked internally; fifo_full and fifo_usedw SHALL NOT be used.
- +1 on fifo_wrreq, -1 on fifo_rdreq, unchanged when both are high in the same cycle.
REQ-021 Write space SHALL be defined as occupancy < 2**FIFO_DEPTH_RADIX, so writes can never overflow the FIFO.
REQ-022 Arbitration SHALL be round-robin with pointer rr_ptr, reset to 0.
- Grant goes to the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- Only when write space exists.
REQ-023 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid high.
- req_ready is combinational from req_valid, rr_ptr and space.
REQ-024 On a grant to i, in the same cycle:
- fifo_wrreq=1;
- fifo_data={i, req_data slice i};
- rr_ptr <= (i+1) mod NUM_REQ at the clock edge.
REQ-025 With no grant, rr_ptr SHALL hold and fifo_wrreq SHALL be 0.
REQ-026 The output stage SHALL be a 2-entry skid buffer (buf_cnt 0..2) with a 1-bit rd_inflight register, set to the previous cycle's fifo_rdreq.
REQ-027 fifo_rdreq SHALL equal !fifo_empty && occupancy!=0 && (buf_cnt + rd_inflight - pop) < 2, where pop = out_valid && out_ready.
REQ-028 When rd_inflight=1, fifo_q SHALL be captured into the buffer tail at the clock edge.
REQ-029 out_valid SHALL equal buf_cnt!=0; out_data and out_id SHALL come from the buffer head.
REQ-030 While out_valid is high and out_ready is low, out_data and out_id SHALL stay stable.
REQ-031 A simultaneous capture and pop SHALL keep buf_cnt unchanged and preserve order.
REQ-032 Latency: a beat accepted in cycle t with an empty system SHALL give out_valid high in cycle t+3.
- t+1 rdreq, t+2 capture edge, t+3 visible.
REQ-033 Sustained throughput SHALL be 1 beat/cycle when out_ready is held high.
REQ-034 Ordering SHALL be strict FIFO: out order equals grant order.

Reset
REQ-035 While sclr is high, the following SHALL be forced to 0 at each clock edge:
- rr_ptr, occupancy, buf_cnt, rd_inflight;
- req_ready, fifo_wrreq, fifo_rdreq, out_valid (outputs).
REQ-036 sclr asserted mid-traffic SHALL discard all buffered and in-flight beats (fifo_sclr clears the FIFO); no beat emerges after reset release until a new grant.
REQ-037 The first cycle after sclr deasserts SHALL accept requests normally.

Verification
REQ-038 Single requester 2 writes 0xA5 in cycle 10 -> out_valid=1, out_data=0xA5, out_id=2 in cycle 13.
REQ-039 All 4 requesters valid continuously, out_ready=1 -> grants 0,1,2,3,0,...; out_id sequence matches; one beat per cycle.
REQ-040 out_ready=0, all valid, depth 8 -> 10 beats accepted (8 FIFO + 2 buffer), then req_ready all 0; occupancy=8; no fifo_wrreq while full.
REQ-041 From REQ-040, set out_ready=1 -> 10 beats emerge in grant order; out_data is stable during each stall cycle.
REQ-042 Requesters 1 and 3 valid, rr_ptr=2 -> grant 3 then 1 then 3.
REQ-043 sclr pulse with 5 beats stored -> out_valid=0 and occupancy=0 the next cycle; no stale beat appears; a new write appears 3 cycles after its grant.
